// File: rtl/keypad_pkg.sv
// Keypad entry shared types: BCD digit, key indices, FSM states,
// command codes and error causes.
package keypad_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK_DIGIT = 4'hF;

  localparam int NUM_KEYS = 13;
  localparam int KEY_CLR  = 10;
  localparam int KEY_DEL  = 11;
  localparam int KEY_ENT  = 12;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ENTRY,
    S_FULL
  } kp_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_DIGIT,
    CMD_CLR,
    CMD_DEL,
    CMD_ENT
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_MULTI,
    ERR_FULL,
    ERR_DEL_EMPTY,
    ERR_ENT_SHORT
  } err_cause_t;

endpackage

// File: rtl/keypad_key_encoder.sv
// Combinational decode of the 13-key vector into a single command,
// a one-hot qualifier and the BCD value of a digit key.
module keypad_key_encoder
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic                one_hot_ok_o,
  output logic                key_is_digit_o,
  output logic [3:0]          bcd_o,
  output cmd_t                cmd_o
);

  logic [NUM_KEYS-1:0] low_clr;

  assign low_clr      = keys_i & (keys_i - NUM_KEYS'(1));
  assign one_hot_ok_o = (keys_i != '0) && (low_clr == '0);
  assign key_is_digit_o = one_hot_ok_o && (|keys_i[9:0]);

  // BCD value of whichever digit key is pressed
  always_comb begin
    bcd_o = BLANK_DIGIT;
    for (int i = 0; i < 10; i++) begin
      if (keys_i[i]) bcd_o = 4'(i);
    end
  end

  // Command class of a single pressed key
  always_comb begin
    cmd_o = CMD_NONE;
    if (one_hot_ok_o) begin
      unique case (1'b1)
        keys_i[KEY_CLR]: cmd_o = CMD_CLR;
        keys_i[KEY_DEL]: cmd_o = CMD_DEL;
        keys_i[KEY_ENT]: cmd_o = CMD_ENT;
        default:         cmd_o = CMD_DIGIT;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: edge-qualified BCD code entry with backspace,
// full-buffer policy and submit handshake. KEYPAD_TIMEOUT_EN adds idle clear.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter bit SHIFT_WHEN_FULL = 1'b1,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   key_digit,
  input  logic                         key_clr,
  input  logic                         key_del,
  input  logic                         key_ent,
  output logic [4*DIGITS-1:0]          disp,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic [4*DIGITS-1:0]          code,
  output logic                         code_valid,
  output logic                         err,
  output logic                         timeout
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
  localparam logic [DW-1:0] BLANK_BUF = {DIGITS{BLANK_DIGIT}};

  logic [NUM_KEYS-1:0] keys;
  logic                any_key;
  logic                one_hot;
  logic                is_digit;
  logic [3:0]          bcd;
  cmd_t                cmd;

  logic                accept;
  logic                multi;
  logic                tmo_fire;

  kp_state_t           state_q, state_d;
  logic                armed_q, armed_d;
  logic [DW-1:0]       disp_q, disp_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DW-1:0]       code_q, code_d;
  logic                cv_q, cv_d;
  err_cause_t          cause_q, cause_d;
  logic                tmo_q, tmo_d;

  assign keys    = {key_ent, key_del, key_clr, key_digit};
  assign any_key = |keys;

  keypad_key_encoder u_enc (
    .keys_i         (keys),
    .one_hot_ok_o   (one_hot),
    .key_is_digit_o (is_digit),
    .bcd_o          (bcd),
    .cmd_o          (cmd)
  );

  assign accept  = armed_q && one_hot;
  assign multi   = armed_q && any_key && !one_hot;
  assign armed_d = !any_key;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_hit;

  assign tmo_hit  = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_fire = tmo_hit && !accept && !multi && (state_q != S_EMPTY);

  // Idle counter: parked at 0 when empty, restarted by any accepted key
  always_comb begin
    tcnt_d = tcnt_q;
    if (accept || tmo_fire || (state_q == S_EMPTY)) begin
      tcnt_d = '0;
    end else if (!tmo_hit) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Event handling: next buffer contents, code and one-cycle pulses
  always_comb begin
    disp_d  = disp_q;
    count_d = count_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    cause_d = ERR_NONE;
    tmo_d   = 1'b0;
    if (multi) begin
      cause_d = ERR_MULTI;
    end else if (accept && is_digit) begin
      if (state_q == S_FULL) begin
        if (SHIFT_WHEN_FULL) disp_d = {disp_q[DW-5:0], bcd};
        else                 cause_d = ERR_FULL;
      end else begin
        disp_d  = {disp_q[DW-5:0], bcd};
        count_d = count_q + CW'(1);
      end
    end else if (accept) begin
      unique case (cmd)
        CMD_CLR: begin
          disp_d  = BLANK_BUF;
          count_d = '0;
        end
        CMD_DEL: begin
          if (state_q == S_EMPTY) begin
            cause_d = ERR_DEL_EMPTY;
          end else begin
            disp_d  = {BLANK_DIGIT, disp_q[DW-1:4]};
            count_d = count_q - CW'(1);
          end
        end
        CMD_ENT: begin
          if (state_q == S_FULL) begin
            code_d  = disp_q;
            cv_d    = 1'b1;
            disp_d  = BLANK_BUF;
            count_d = '0;
          end else begin
            cause_d = ERR_ENT_SHORT;
          end
        end
        default: ;
      endcase
    end else if (tmo_fire) begin
      disp_d  = BLANK_BUF;
      count_d = '0;
      tmo_d   = 1'b1;
    end
  end

  // FSM next state follows the resulting digit count
  always_comb begin
    state_d = S_ENTRY;
    if (count_d == '0)          state_d = S_EMPTY;
    else if (count_d == CNT_FULL) state_d = S_FULL;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  // Datapath and pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b1;
      disp_q  <= BLANK_BUF;
      count_q <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
      cause_q <= ERR_NONE;
      tmo_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      disp_q  <= disp_d;
      count_q <= count_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
    end
  end

  assign disp       = disp_q;
  assign count      = count_q;
  assign full       = (state_q == S_FULL);
  assign code       = code_q;
  assign code_valid = cv_q;
  assign err        = (cause_q != ERR_NONE);
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer: two instances share the keys,
// one per full-buffer policy.
module tb_keypad_entry_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  key_digit = '0;
  logic        key_clr = 1'b0;
  logic        key_del = 1'b0;
  logic        key_ent = 1'b0;

  logic [15:0] disp, disp_n, code, code_n;
  logic [2:0]  count, count_n;
  logic        full, full_n, cv, cv_n, err, err_n, tmo, tmo_n;

  int n_chk  = 0;
  int n_pass = 0;

  logic cap_cv, cap_err, cap_err_n, cap_tmo;

  localparam logic [12:0] K_CLR = 13'h0400;
  localparam logic [12:0] K_DEL = 13'h0800;
  localparam logic [12:0] K_ENT = 13'h1000;

  always #5 clk = ~clk;

  keypad_entry_buffer #(
    .DIGITS(4), .SHIFT_WHEN_FULL(1'b1), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .rst(rst), .key_digit(key_digit), .key_clr(key_clr),
    .key_del(key_del), .key_ent(key_ent), .disp(disp), .count(count),
    .full(full), .code(code), .code_valid(cv), .err(err), .timeout(tmo)
  );

  keypad_entry_buffer #(
    .DIGITS(4), .SHIFT_WHEN_FULL(1'b0), .TIMEOUT_CYCLES(16)
  ) u_dut_ns (
    .clk(clk), .rst(rst), .key_digit(key_digit), .key_clr(key_clr),
    .key_del(key_del), .key_ent(key_ent), .disp(disp_n), .count(count_n),
    .full(full_n), .code(code_n), .code_valid(cv_n), .err(err_n),
    .timeout(tmo_n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [12:0] dg(input int d);
    logic [12:0] one;
    one = 13'd1;
    return one << d;
  endfunction

  task automatic drive(input logic [12:0] k);
    {key_ent, key_del, key_clr, key_digit} = k;
  endtask

  // one-cycle press then one-cycle release; pulses captured in between
  task automatic press(input logic [12:0] k);
    @(negedge clk);
    drive(k);
    @(negedge clk);
    cap_cv    = cv;
    cap_err   = err;
    cap_err_n = err_n;
    cap_tmo   = tmo;
    drive('0);
  endtask

  initial begin
    logic seen_err, seen_tmo;
    int   tmo_at;

    #1 rst = 1'b0;
    #2;
    chk("rst_disp", disp, 16'hFFFF);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_code", code, 0);
    chk("rst_pulses", {cv, err, tmo}, 0);
    @(negedge clk);
    rst = 1'b1;

    press(dg(1)); press(dg(2)); press(dg(3)); press(dg(4));
    chk("d1234_disp", disp, 16'h1234);
    chk("d1234_count", count, 4);
    chk("d1234_full", full, 1);
    press(K_ENT);
    chk("ent_cv", cap_cv, 1);
    chk("ent_err", cap_err, 0);
    chk("ent_code", code, 16'h1234);
    chk("ent_disp", disp, 16'hFFFF);
    chk("ent_count", count, 0);
    chk("ent_full", full, 0);
    @(negedge clk);
    chk("ent_cv_drop", cv, 0);

    // hold digit 7 for ten cycles
    seen_err = 1'b0;
    @(negedge clk);
    drive(dg(7));
    repeat (10) begin
      @(negedge clk);
      seen_err |= err;
    end
    drive('0);
    @(negedge clk);
    chk("hold_err", seen_err, 0);
    chk("hold_disp", disp, 16'hFFF7);
    chk("hold_count", count, 1);
    press(K_CLR);
    chk("clr_disp", disp, 16'hFFFF);

    press(dg(5)); press(dg(6)); press(dg(7)); press(dg(8));
    press(dg(9));
    chk("shift_disp", disp, 16'h6789);
    chk("shift_count", count, 4);
    chk("shift_err", cap_err, 0);
    chk("noshift_disp", disp_n, 16'h5678);
    chk("noshift_count", count_n, 4);
    chk("noshift_err", cap_err_n, 1);
    press(K_CLR);

    press(dg(1)); press(dg(2)); press(dg(3));
    press(K_DEL);
    chk("del_disp", disp, 16'hFF12);
    chk("del_count", count, 2);
    chk("del_err", cap_err, 0);
    press(K_ENT);
    chk("ent_short_err", cap_err, 1);
    chk("ent_short_cv", cap_cv, 0);
    chk("ent_short_disp", disp, 16'hFF12);
    chk("ent_short_code", code, 16'h1234);
    press(K_CLR);
    chk("clr_err", cap_err, 0);
    chk("clr_count", count, 0);
    press(K_DEL);
    chk("del_empty_err", cap_err, 1);
    chk("del_empty_disp", disp, 16'hFFFF);

    press(dg(3) | dg(4));
    chk("multi_err", cap_err, 1);
    chk("multi_disp", disp, 16'hFFFF);
    chk("multi_count", count, 0);
    press(dg(4));
    chk("after_multi_disp", disp, 16'hFFF4);
    chk("after_multi_err", cap_err, 0);
    press(K_CLR);

`ifdef KEYPAD_TIMEOUT_EN
    @(negedge clk);
    drive(dg(9));
    @(posedge clk);
    tmo_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      drive('0);
      if (tmo && tmo_at == 0) tmo_at = k;
    end
    chk("tmo_cycle", tmo_at, 16);
    chk("tmo_disp", disp, 16'hFFFF);
    chk("tmo_count", count, 0);
`else
    press(dg(9));
    seen_tmo = cap_tmo;
    repeat (20) begin
      @(negedge clk);
      seen_tmo |= tmo;
    end
    chk("no_tmo", seen_tmo, 0);
    chk("no_tmo_disp", disp, 16'hFFF9);
    press(K_CLR);
`endif

    // async reset mid-entry, checked before the next clock edge
    press(dg(1)); press(dg(2));
    chk("pre_rst_disp", disp, 16'hFF12);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_disp", disp, 16'hFFFF);
    chk("arst_count", count, 0);
    chk("arst_code", code, 0);
    chk("arst_full", {full, cv, err, tmo}, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Parametrised keypad entry stage for the door-lock datapath: takes one-hot digit keys plus clear/delete/enter keys and builds a DIGITS-long BCD code with press-once edge qualification. It supports backspace, configurable full-buffer policy and a submitted-code handshake. It sits between the keypad input synchronisers and the code comparator and display driver.

## Interface
- DIGITS, 4, number of BCD digits held (≥2)
- SHIFT_WHEN_FULL, 1, 1: digit on full buffer drops oldest; 0: digit ignored, err pulses
- TIMEOUT_CYCLES, 50_000_000, inactivity clear interval (used only with KEYPAD_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- key_digit  in  10  one-hot digit keys, bit i = digit i, already synchronised
- key_clr  in  1  clear key
- key_del  in  1  delete-last-digit key
- key_ent  in  1  enter/submit key
- disp  out  4*DIGITS  current entry; disp[3:0] = most recent digit, unused slots = 4'hF
- count  out  $clog2(DIGITS+1)  digits entered
- full  out  1  count == DIGITS
- code  out  4*DIGITS  last submitted code, same ordering as disp
- code_valid  out  1  one-cycle pulse: code updated
- err  out  1  one-cycle pulse: rejected action
- timeout  out  1  one-cycle pulse: buffer cleared by inactivity (0 without macro)

## Operation
- Reset (rst low, async): disp all 4'hF, count 0, full 0, code 0, code_valid/err/timeout 0, armed 1, state EMPTY.
- 13 keys sampled each edge. Accepted event: armed=1 and exactly one key high. Any key high clears armed; armed returns to 1 after one edge with all 13 keys low. Holding a key yields one event.
- Two or more keys high while armed: no action, err pulses, armed cleared.
- FSM states: EMPTY (count 0), ENTRY (0<count<DIGITS), FULL (count==DIGITS); state derived from count after every event.
- Digit d: EMPTY/ENTRY: disp shifts up one nibble, disp[3:0]=d, count+1. FULL: SHIFT_WHEN_FULL=1 shifts and drops oldest, count unchanged; =0 no change, err.
- key_del: count>0: disp shifts down one nibble, top nibble = 4'hF, count−1. EMPTY: err.
- key_clr: disp all 4'hF, count 0 (no err in EMPTY).
- key_ent: FULL: code←disp, code_valid pulses, buffer cleared to EMPTY same edge. Otherwise: err, buffer unchanged.
- code holds until next valid submit or reset.

## Timing
- Event keys high before edge k: disp/count/full/code updated at edge k; code_valid/err/timeout high for the cycle after edge k only.
- Released-idle gap of one cycle is sufficient to re-arm; press at edge k, release at k+1, press at k+2 yields two events.
- At most one of code_valid/err/timeout asserted per cycle; an accepted event at the same edge as timeout expiry takes precedence and suppresses timeout.
- Reset mid-entry discards the entry and code immediately; outputs return to reset values asynchronously.

## Configuration
- KEYPAD_TIMEOUT_EN defined: counter runs while count>0, reloads on every accepted event or clear; on reaching TIMEOUT_CYCLES−1 cycles idle, buffer cleared to EMPTY and timeout pulses. Counter held at 0 in EMPTY.
- Not defined: no counter logic, timeout tied 0, TIMEOUT_CYCLES ignored.

## Structure
- keypad_pkg: bcd_t (4-bit), BLANK_DIGIT = 4'hF, key-index constants (0–9, CLR=10, DEL=11, ENT=12), err cause constants.
- Sub-module keypad_key_encoder: combinational 13-key vector → one_hot_ok, key_is_digit, BCD value, command code; instanced once.

## Test plan
- Reset, press 1,2,3,4 (one-cycle presses, one-cycle gaps) → disp=16'h1234 after last, count=4, full=1; ent → code=16'h1234, code_valid one cycle, disp=16'hFFFF, count=0.
- Hold digit 7 for 10 cycles → single event, disp=16'hFFF7, count=1.
- Enter 5,6,7,8 then 9 with SHIFT_WHEN_FULL=1 → disp=16'h6789; with =0 → disp=16'h5678, err pulse.
- Enter 1,2,3, del → disp=16'hFF12, count=2; ent → err, disp unchanged; del on EMPTY → err.
- Keys 3 and 4 together → err, no change; release one cycle, press 4 → disp=16'hFFF4.
- KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=16: enter 9, idle → timeout pulse at cycle 16, disp=16'hFFFF; assert rst low mid-entry → all outputs reset without clock edge.
